// File: rtl/button_debounce_pulse_pkg.sv
// Shared types and defaults for the push-button debouncer.
// State encoding, default timing constants and counter sizing helper.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_REPEAT_DELAY    = 50000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 10000000;

  // Bits needed to hold values 0..n_max, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n_max);
    int unsigned w;
    w = $clog2(n_max + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_debounce_pulse_sync_chain.sv
// Multi-flop synchroniser for a single asynchronous bit; q is the last stage.
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[STAGES-2:0], d};
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/button_debounce_pulse.sv
// Push-button conditioner: synchronise, debounce, emit level plus press/release pulses.
// Optional auto-repeat of btn_pulse while held is enabled by defining BTN_REPEAT_EN.
module button_debounce_pulse
  import btn_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_pulse,
  output logic btn_release
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  state_t          r_state, w_state_nx;
  logic [CW-1:0]   r_cnt, w_cnt_nx;
  logic            r_level, w_level_nx;
  logic            r_pulse, w_pulse_nx;
  logic            r_release, w_release_nx;
  logic            w_s;

`ifdef BTN_REPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = cnt_width(RMAX);
  localparam logic [RW-1:0] RPT_DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] r_rpt, w_rpt_nx;
  logic          r_rpt_run, w_rpt_run_nx;
`endif

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (w_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_pulse   <= 1'b0;
      r_release <= 1'b0;
`ifdef BTN_REPEAT_EN
      r_rpt     <= '0;
      r_rpt_run <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_level   <= w_level_nx;
      r_pulse   <= w_pulse_nx;
      r_release <= w_release_nx;
`ifdef BTN_REPEAT_EN
      r_rpt     <= w_rpt_nx;
      r_rpt_run <= w_rpt_run_nx;
`endif
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_level_nx   = r_level;
    w_pulse_nx   = 1'b0;
    w_release_nx = 1'b0;
`ifdef BTN_REPEAT_EN
    w_rpt_nx     = r_rpt;
    w_rpt_run_nx = r_rpt_run;
`endif
    case (r_state)
      IDLE: begin
        if (w_s) begin
          w_state_nx = PRESS_CHK;
          w_cnt_nx   = '0;
        end
      end
      PRESS_CHK: begin
        if (!w_s) begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nx = HELD;
          w_cnt_nx   = '0;
          w_level_nx = 1'b1;
          w_pulse_nx = 1'b1;
`ifdef BTN_REPEAT_EN
          w_rpt_nx     = '0;
          w_rpt_run_nx = 1'b0;
`endif
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!w_s) begin
          w_state_nx = RELEASE_CHK;
          w_cnt_nx   = '0;
        end else begin
`ifdef BTN_REPEAT_EN
          // r_rpt_run marks that the initial delay has elapsed; afterwards the period applies.
          if (r_rpt == (r_rpt_run ? RPT_PERIOD_LAST : RPT_DELAY_LAST)) begin
            w_pulse_nx   = 1'b1;
            w_rpt_nx     = '0;
            w_rpt_run_nx = 1'b1;
          end else begin
            w_rpt_nx = r_rpt + 1'b1;
          end
`endif
        end
      end
      RELEASE_CHK: begin
        if (w_s) begin
          w_state_nx = HELD;
          w_cnt_nx   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nx   = IDLE;
          w_cnt_nx     = '0;
          w_level_nx   = 1'b0;
          w_release_nx = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  assign btn_level   = r_level;
  assign btn_pulse   = r_pulse;
  assign btn_release = r_release;

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Directed bench for button_debounce_pulse (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Repeat-pulse expectations switch on when BTN_REPEAT_EN is defined.
module tb_button_debounce_pulse;

  logic clk;
  logic rst;
  logic btn_in;
  logic btn_level;
  logic btn_pulse;
  logic btn_release;

  int n_total;
  int n_bad;

  button_debounce_pulse #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_pulse   (btn_pulse),
    .btn_release (btn_release)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    logic exp_p;
    n_total = 0;
    n_bad   = 0;
    rst     = 1'b1;
    btn_in  = 1'b0;
    repeat (3) tick();
    check("reset_level",   btn_level,   1'b0);
    check("reset_pulse",   btn_pulse,   1'b0);
    check("reset_release", btn_release, 1'b0);

    // Clean press: pulse and level at edge 2+4+1 = 7.
    rst    = 1'b0;
    btn_in = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("press_pulse_e%0d", e), btn_pulse, e == 7);
      check($sformatf("press_level_e%0d", e), btn_level, e >= 7);
      check($sformatf("press_rel_e%0d", e),   btn_release, 1'b0);
    end

    // Clean release, symmetric latency.
    btn_in = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("rel_release_e%0d", e), btn_release, e == 7);
      check($sformatf("rel_level_e%0d", e),   btn_level, e < 7);
      check($sformatf("rel_pulse_e%0d", e),   btn_pulse, 1'b0);
    end
    repeat (4) tick();

    // Bounce 1,0,1,0 then settle low: nothing accepted.
    for (int i = 0; i < 14; i++) begin
      btn_in = (i < 4) ? ((i % 2) == 0) : 1'b0;
      tick();
      check($sformatf("bounce_pulse_%0d", i), btn_pulse, 1'b0);
      check($sformatf("bounce_level_%0d", i), btn_level, 1'b0);
    end

    // Press to HELD, then release with a one-cycle high glitch that lands in RELEASE_CHK.
    btn_in = 1'b1;
    repeat (8) tick();
    check("glitch_setup_level", btn_level, 1'b1);
    for (int e = 1; e <= 12; e++) begin
      btn_in = (e == 4);
      tick();
      check($sformatf("glitch_release_e%0d", e), btn_release, e == 11);
      check($sformatf("glitch_level_e%0d", e),   btn_level, e < 11);
    end
    btn_in = 1'b0;
    repeat (4) tick();

    // Reset during PRESS_CHK (cnt=2 after the fifth edge), held for 3 cycles.
    btn_in = 1'b1;
    repeat (5) tick();
    check("midrst_pre_pulse", btn_pulse, 1'b0);
    rst = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check($sformatf("midrst_in_pulse_e%0d", e), btn_pulse, 1'b0);
      check($sformatf("midrst_in_level_e%0d", e), btn_level, 1'b0);
    end
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("midrst_pulse_e%0d", e), btn_pulse, e == 7);
      check($sformatf("midrst_level_e%0d", e), btn_level, e >= 7);
    end

    // Asynchronous reset between edges while HELD.
    #3;
    check("async_pre_level", btn_level, 1'b1);
    rst = 1'b1;
    #1;
    check("async_level",   btn_level,   1'b0);
    check("async_pulse",   btn_pulse,   1'b0);
    check("async_release", btn_release, 1'b0);
    #1;
    rst = 1'b0;

    // Still held: a fresh press check, then optional auto-repeat at +10, +15, +20.
    for (int e = 1; e <= 28; e++) begin
      tick();
      exp_p = (e == 7);
`ifdef BTN_REPEAT_EN
      exp_p = exp_p || (e == 17) || (e == 22) || (e == 27);
`endif
      check($sformatf("hold_pulse_e%0d", e), btn_pulse, exp_p);
      check($sformatf("hold_level_e%0d", e), btn_level, e >= 7);
    end
    btn_in = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      check($sformatf("final_pulse_e%0d", e),   btn_pulse, 1'b0);
      check($sformatf("final_release_e%0d", e), btn_release, e == 7);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/button_debounce_pulse.md
Name: button_debounce_pulse

Overview:
- Upstream conditioner for the 1-bit control signal fed into D_signal_delay's D input.
- Takes a raw asynchronous push-button or switch input and synchronises it to clk.
- Filters contact bounce with a stability counter, then emits a debounced level plus single-cycle press and release pulses.
- btn_pulse drives the delay stage directly.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on btn_in (legal range 2..4).
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a level change (minimum 1).
- REPEAT_DELAY, 50000000, cycles in HELD before the first auto-repeat pulse (used only with the macro).
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat pulses (used only with the macro).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- btn_in  input  1  raw, unsynchronised button input.
- btn_level  output  1  debounced button level.
- btn_pulse  output  1  one-cycle pulse on an accepted press (and on auto-repeat, when enabled).
- btn_release  output  1  one-cycle pulse on an accepted release.

Behaviour:
- Reset: while rst=1, synchroniser flops=0, state=IDLE, counters=0, btn_level=0, btn_pulse=0, btn_release=0. All outputs are registered.
- Synchroniser: a SYNC_STAGES-deep flop chain. The last stage is s. No logic on btn_in before the first flop.
- Counter: width = $clog2(DEBOUNCE_CYCLES+1). It is cleared on every state change and never wraps.
- IDLE (btn_level=0): if s=1, go to PRESS_CHK with cnt=0.
- PRESS_CHK:
  - s=0: back to IDLE, cnt=0 (bounce rejected, no pulse).
  - s=1 and cnt==DEBOUNCE_CYCLES-1: go to HELD, btn_level<=1, btn_pulse<=1 for exactly one cycle.
  - Otherwise: cnt++.
- HELD (btn_level=1): if s=0, go to RELEASE_CHK with cnt=0.
- RELEASE_CHK:
  - s=1: back to HELD (no pulse).
  - s=0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE, btn_level<=0, btn_release<=1 for one cycle.
  - Otherwise: cnt++.
- Latency: btn_in rises before edge 1 and stays stable. Then btn_pulse and btn_level are high after edge SYNC_STAGES+DEBOUNCE_CYCLES+1. Release latency is symmetric.
- Pulse rules:
  - btn_pulse and btn_release are never high in the same cycle.
  - Neither is ever high two consecutive cycles, except for the repeat rule below.
- Bounce: any s toggle during a CHK state restarts the check from the stable state. An endless bounce produces no output change.
- Reset mid-operation: all state is discarded with no pulse emitted. If the button is still held after rst drops, the full press check repeats and yields a fresh btn_pulse.
- DEBOUNCE_CYCLES=1: a level change is accepted after one cycle in the CHK state.

Optional Feature:
- Macro: BTN_REPEAT_EN.
- Defined:
  - A repeat counter runs only in HELD and is cleared on entry to HELD.
  - The first extra btn_pulse fires after REPEAT_DELAY cycles in HELD, then every REPEAT_PERIOD cycles while HELD persists.
  - RELEASE_CHK freezes the repeat counter. Returning to HELD from a rejected release resumes it without clearing.
  - Each repeat pulse is still one cycle wide.
- Undefined: no repeat counter is synthesised, and exactly one btn_pulse is produced per accepted press.

Decomposition:
- Package btn_pkg:
  - State encoding constants: IDLE=2'd0, PRESS_CHK=2'd1, HELD=2'd2, RELEASE_CHK=2'd3.
  - Default timing constants.
  - Counter-width function.
- One sub-module, sync_chain (parameter STAGES, ports clk, rst, d, q), instantiated once for the synchroniser.
- FSM and counters stay in the top module.

Test Plan:
- SYNC_STAGES=2, DEBOUNCE_CYCLES=4; rst released; btn_in 0->1 before edge 1 and held -> btn_pulse=1 only after edge 7, btn_level=1 from edge 7 onward.
- Same setup; btn_in toggles 1,0,1,0 on successive cycles, then stays 0 -> no btn_pulse, btn_level stays 0.
- Held press, then btn_in=0 stable -> btn_release one cycle at release+7 edges, btn_level=0. A single-cycle high glitch during RELEASE_CHK -> stays HELD, no btn_release.
- rst=1 asserted mid PRESS_CHK (cnt=2) while btn_in=1, released after 3 cycles -> outputs 0 during reset, btn_pulse 7 edges after rst deasserts.
- BTN_REPEAT_EN defined, REPEAT_DELAY=10, REPEAT_PERIOD=5, hold 30 cycles -> btn_pulse at press, then +10, +15, +20 cycles after the press pulse; none after release.
- Async reset check: rst pulsed between clock edges -> outputs clear immediately, before the next posedge.
